top: RTL and testbench



---
 rtl/top_pkg.sv | 32 +++
 rtl/top_if.sv | 9 +
 rtl/top_regfile.sv | 43 ++++
 rtl/top.sv | 121 ++++++++++++
 tb/tb_top.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/top_pkg.sv
// Shared constants and types for the single-cycle MIPS-subset bring-up core.
package top_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam int ROM_WORDS = 16;

    localparam logic [4:0] T0 = 5'd8;
    localparam logic [4:0] T1 = 5'd9;
    localparam logic [4:0] T2 = 5'd10;
    localparam logic [4:0] T3 = 5'd11;
    localparam logic [4:0] T4 = 5'd12;
    localparam logic [4:0] T5 = 5'd13;
    localparam logic [4:0] T6 = 5'd14;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

endpackage

// File: rtl/top_if.sv
// Start-address input and debug fetch view of the core, grouped for port reuse.
interface top_if;
    logic [31:0] pc;
    logic [31:0] dbg_pc;
    logic [31:0] dbg_instr;

    modport master (output pc, input dbg_pc, input dbg_instr);
    modport slave  (input pc, output dbg_pc, output dbg_instr);
endinterface

// File: rtl/top_regfile.sv
// 32x32 register file: two async read ports, one sync write port, $0 hard-wired to zero.
module regfile
    import top_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] t2;
    logic        unused_dbg;

    // Reset wins over any write; register i comes up holding i.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'(i);
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];

    // Debug taps, only read from outside through the hierarchy.
    assign t0 = regs[T0];
    assign t1 = regs[T1];
    assign t2 = regs[T2];
    assign unused_dbg = ^{t0, t1, t2};

endmodule

// File: rtl/top.sv
// Single-cycle MIPS-subset core: fixed 16-word ROM, decoder, ALU and PC inline; regfile as r1.
module top
    import top_pkg::*;
(
    input  logic clk,
    input  logic rst,
    top_if.slave bus
);

    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sx;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    alu_op_t     alu_op;
    logic        we;
    logic [4:0]  wa;
    logic        is_j;
    logic        unused_bits;

    // Addresses past the ROM fetch zero, which decodes as a NOP.
    always_comb begin
        instr = 32'h0;
        if (pc_q < 32'(ROM_WORDS * 4)) begin
            case (pc_q[5:2])
                4'h0:    instr = 32'h20080005;
                4'h1:    instr = 32'h2009000C;
                4'h2:    instr = 32'h01285022;
                4'h3:    instr = 32'h01285820;
                4'h4:    instr = 32'h01286024;
                4'h5:    instr = 32'h01286825;
                4'h6:    instr = 32'h0109702A;
                4'h7:    instr = 32'h08000007;
                default: instr = 32'h0;
            endcase
        end
    end

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm_sx = {{16{instr[15]}}, instr[15:0]};

    always_comb begin
        we     = 1'b0;
        wa     = rd;
        alu_op = ALU_ADD;
        alu_b  = rd2;
        is_j   = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   begin we = 1'b1; alu_op = ALU_ADD; end
                    F_SUB:   begin we = 1'b1; alu_op = ALU_SUB; end
                    F_AND:   begin we = 1'b1; alu_op = ALU_AND; end
                    F_OR:    begin we = 1'b1; alu_op = ALU_OR;  end
                    F_SLT:   begin we = 1'b1; alu_op = ALU_SLT; end
                    default: we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                we    = 1'b1;
                wa    = rt;
                alu_b = imm_sx;
            end
            OP_J:    is_j = 1'b1;
            default: we = 1'b0;
        endcase
    end

    always_comb begin
        alu_y = 32'h0;
        case (alu_op)
            ALU_ADD: alu_y = rd1 + alu_b;
            ALU_SUB: alu_y = rd1 - alu_b;
            ALU_AND: alu_y = rd1 & alu_b;
            ALU_OR:  alu_y = rd1 | alu_b;
            ALU_SLT: alu_y = ($signed(rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_y = 32'h0;
        endcase
    end

    regfile r1 (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (we),
        .wa  (wa),
        .wd  (alu_y)
    );

    assign next_pc = is_j ? {pc_q[31:28], instr[25:0], 2'b00} : (pc_q + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= {bus.pc[31:2], 2'b00};
        end else begin
            pc_q <= next_pc;
        end
    end

    assign bus.dbg_pc    = pc_q;
    assign bus.dbg_instr = instr;

    // Shamt and the low start-address bits carry no meaning here.
    assign unused_bits = ^{instr[10:6], bus.pc[1:0]};

endmodule

// File: tb/tb_top.sv
// Bench for top: vector table, hand sequences, and random runs against an instruction-level model.
module tb_top;
    import top_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    top_if bus_if ();
    top dut (.clk(clk), .rst(rst), .bus(bus_if));

    logic        rf_rst = 1'b1;
    logic        rf_we  = 1'b0;
    logic [4:0]  rf_ra1 = 5'd0;
    logic [4:0]  rf_ra2 = 5'd0;
    logic [4:0]  rf_wa  = 5'd0;
    logic [31:0] rf_wd  = 32'h0;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;

    regfile rf_chk (
        .clk(clk), .rst(rf_rst), .ra1(rf_ra1), .ra2(rf_ra2), .rd1(rf_rd1), .rd2(rf_rd2),
        .we(rf_we), .wa(rf_wa), .wd(rf_wd)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_reg(input int i);
        return dut.r1.regs[i];
    endfunction

    // Instruction-set model: program image, architectural registers and PC.
    logic [31:0] rom_img [16];
    logic [31:0] m_regs  [32];
    logic [31:0] m_pc;

    function automatic logic [31:0] fetch(input logic [31:0] p);
        if (p < 32'd64) return rom_img[p / 4];
        return 32'h0;
    endfunction

    task automatic model_reset(input logic [31:0] start);
        m_pc = start & ~32'd3;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, res;
        int dest;
        ins  = fetch(m_pc);
        a    = m_regs[ins[25:21]];
        b    = m_regs[ins[20:16]];
        dest = -1;
        res  = 0;
        if (ins[31:26] == 6'd0) begin
            dest = int'(ins[15:11]);
            case (ins[5:0])
                6'h20:   res = a + b;
                6'h22:   res = a - b;
                6'h24:   res = a & b;
                6'h25:   res = a | b;
                6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: dest = -1;
            endcase
        end else if (ins[31:26] == 6'h08) begin
            dest = int'(ins[20:16]);
            res  = a + {{16{ins[15]}}, ins[15:0]};
        end
        if (dest > 0) m_regs[dest] = res;
        if (ins[31:26] == 6'h02) m_pc = {m_pc[31:28], ins[25:0], 2'b00};
        else m_pc = m_pc + 32'd4;
    endtask

    task automatic dut_reset(input logic [31:0] start);
        rst       = 1'b1;
        bus_if.pc = start;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [31:0] start;
        int          edges;
        int          ridx;
        logic [31:0] exp_reg;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [18];

    initial begin
        rom_img = '{32'h20080005, 32'h2009000C, 32'h01285022, 32'h01285820,
                    32'h01286024, 32'h01286825, 32'h0109702A, 32'h08000007,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        bus_if.pc = 32'h0;

        vecs[0]  = '{32'h08, 0, 8, 32'h8, 32'h08, 32'h01285022};
        vecs[1]  = '{32'h08, 0, 10, 32'hA, 32'h08, 32'h01285022};
        vecs[2]  = '{32'h08, 1, 10, 32'h1, 32'h0C, 32'h01285820};
        vecs[3]  = '{32'h08, 1, 8, 32'h8, 32'h0C, 32'h01285820};
        vecs[4]  = '{32'h08, 1, 9, 32'h9, 32'h0C, 32'h01285820};
        vecs[5]  = '{32'h08, 4, 11, 32'h11, 32'h18, 32'h0109702A};
        vecs[6]  = '{32'h08, 4, 12, 32'h8, 32'h18, 32'h0109702A};
        vecs[7]  = '{32'h08, 4, 13, 32'h9, 32'h18, 32'h0109702A};
        vecs[8]  = '{32'h08, 5, 14, 32'h1, 32'h1C, 32'h08000007};
        vecs[9]  = '{32'h00, 3, 10, 32'h7, 32'h0C, 32'h01285820};
        vecs[10] = '{32'h00, 7, 12, 32'h4, 32'h1C, 32'h08000007};
        vecs[11] = '{32'h00, 7, 13, 32'hD, 32'h1C, 32'h08000007};
        vecs[12] = '{32'h00, 40, 14, 32'h1, 32'h1C, 32'h08000007};
        vecs[13] = '{32'h0B, 1, 10, 32'h1, 32'h0C, 32'h01285820};
        vecs[14] = '{32'h100, 5, 8, 32'h8, 32'h114, 32'h0};
        vecs[15] = '{32'hFFFFFFFC, 1, 8, 32'h8, 32'h0, 32'h20080005};
        vecs[16] = '{32'hFFFFFFFC, 2, 8, 32'h5, 32'h4, 32'h2009000C};
        vecs[17] = '{32'h00, 3, 9, 32'hC, 32'h0C, 32'h01285820};

        for (int v = 0; v < 18; v++) begin
            dut_reset(vecs[v].start);
            run_edges(vecs[v].edges);
            check($sformatf("vec%0d_reg%0d", v, vecs[v].ridx), dut_reg(vecs[v].ridx), vecs[v].exp_reg);
            check($sformatf("vec%0d_pc", v), bus_if.dbg_pc, vecs[v].exp_pc);
            check($sformatf("vec%0d_instr", v), bus_if.dbg_instr, vecs[v].exp_instr);
        end

        // Out-of-range fetch leaves every register at its reset value.
        dut_reset(32'h100);
        run_edges(6);
        for (int i = 1; i < 32; i++) check($sformatf("oor_reg%0d", i), dut_reg(i), 32'(i));
        check("oor_pc", bus_if.dbg_pc, 32'h118);

        // Reset in the middle of the program: sub at 0x08 must not land.
        dut_reset(32'h00);
        run_edges(2);
        check("mid_pre_t0", dut.r1.t0, 32'h5);
        rst = 1'b1;
        run_edges(1);
        rst = 1'b0;
        check("mid_t0", dut.r1.t0, 32'h8);
        check("mid_t1", dut.r1.t1, 32'h9);
        check("mid_t2", dut.r1.t2, 32'hA);
        check("mid_pc", bus_if.dbg_pc, 32'h0);
        run_edges(3);
        check("mid_restart_t2", dut.r1.t2, 32'h7);
        check("mid_restart_pc", bus_if.dbg_pc, 32'h0C);

        // Standalone register file: $0 protection and reset priority.
        rf_rst = 1'b1;
        run_edges(1);
        rf_rst = 1'b0;
        rf_we  = 1'b1;
        rf_wa  = 5'd0;
        rf_wd  = 32'hFFFFFFFF;
        run_edges(1);
        rf_we  = 1'b0;
        rf_ra1 = 5'd0;
        rf_ra2 = 5'd5;
        #1;
        check("rf_zero_rd1", rf_rd1, 32'h0);
        check("rf_init5", rf_rd2, 32'h5);
        check("rf_zero_store", rf_chk.regs[0], 32'h0);
        rf_we = 1'b1;
        rf_wa = 5'd5;
        rf_wd = 32'hA5A5A5A5;
        run_edges(1);
        rf_we = 1'b0;
        check("rf_write5", rf_rd2, 32'hA5A5A5A5);
        rf_ra1 = 5'd5;
        #1;
        check("rf_write5_port1", rf_rd1, 32'hA5A5A5A5);
        rf_rst = 1'b1;
        rf_we  = 1'b1;
        rf_wd  = 32'hDEADBEEF;
        run_edges(1);
        rf_rst = 1'b0;
        rf_we  = 1'b0;
        check("rf_rst_priority", rf_rd2, 32'h5);
        rf_ra1 = 5'd31;
        #1;
        check("rf_init31", rf_rd1, 32'd31);

        // Random start points and run lengths against the model.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] start;
            int n;
            case ($urandom_range(0, 2))
                0:       start = 32'($urandom_range(0, 63));
                1:       start = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
                default: start = $urandom;
            endcase
            n = $urandom_range(1, 12);
            dut_reset(start);
            model_reset(start);
            for (int k = 0; k < n; k++) begin
                check($sformatf("rnd%0d_pc", t), bus_if.dbg_pc, m_pc);
                check($sformatf("rnd%0d_instr", t), bus_if.dbg_instr, fetch(m_pc));
                model_step();
                run_edges(1);
                for (int r = 8; r <= 14; r++)
                    check($sformatf("rnd%0d_reg%0d", t, r), dut_reg(r), m_regs[r]);
            end
            check($sformatf("rnd%0d_endpc", t), bus_if.dbg_pc, m_pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
